// File: rtl/line_fetch_engine_pkg.sv
// Shared definitions for the PSRAM line fetch engine: FSM encoding and
// default geometry constants.
package line_fetch_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        BURST,
        ADV
    } fetch_state_t;

    localparam int unsigned DEF_ADDR_W      = 23;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_LINE_WORDS  = 128;
    localparam int unsigned DEF_NUM_LINES   = 4;
    localparam int unsigned DEF_FRAME_WORDS = 153600;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
module bram_sdp #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_fetch_engine.sv
// Fetches frame lines from PSRAM by burst into a ring of line slots and
// streams them out as 16bpp words or 8bpp byte pairs.
module line_fetch_engine
    import line_fetch_engine_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES   = DEF_NUM_LINES,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_W-1:0]                frame_base,
    input  logic                             frame_start,
    input  logic                             mode_16bpp,
    input  logic                             ctrlr_good,
    input  logic                             op_begun,
    input  logic                             data_ok,
    input  logic [DATA_W-1:0]                data,
    output logic                             req_access,
    output logic                             rd,
    output logic                             burst,
    output logic [ADDR_W-1:0]                addr,
    input  logic                             pix_ready,
    output logic                             pix_valid,
    output logic [DATA_W-1:0]                pix_data,
    output logic [$clog2(NUM_LINES+1)-1:0]   lines_avail,
    output logic                             underflow
);

    localparam int unsigned WW = $clog2(LINE_WORDS);
    localparam int unsigned SW = $clog2(NUM_LINES);
    localparam int unsigned CW = $clog2(NUM_LINES + 1);

    fetch_state_t     state, state_nx;
    logic [WW-1:0]    word_cnt;
    logic [ADDR_W-1:0] line_off;
    logic [ADDR_W:0]  next_off;
    logic             wrap;
    logic [SW-1:0]    wr_slot;
    logic             pending;
    logic             flush_now, commit;

    logic [SW+WW-1:0] rd_ptr, raddr;
    logic             byte_sel, line_mode, cur_mode, word_done;
    logic             xfer, adv_word, last_pix, seen_commit;
    logic [DATA_W-1:0] q;
    logic [7:0]       pix_byte;

    always_comb begin
        state_nx   = state;
        req_access = 1'b0;
        rd         = 1'b0;
        burst      = 1'b0;
        case (state)
            IDLE:  if (ctrlr_good && (lines_avail < CW'(NUM_LINES))) state_nx = REQ;
            REQ: begin
                req_access = 1'b1;
                rd         = 1'b1;
                if (op_begun) state_nx = WAIT;
            end
            WAIT: begin
                req_access = 1'b1;
                if (data_ok) state_nx = BURST;
            end
            BURST: begin
                req_access = 1'b1;
                burst      = 1'b1;
                if (word_cnt == WW'(LINE_WORDS - 1)) state_nx = ADV;
            end
            ADV:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A restart during a fetch is deferred to ADV so the burst completes and its line is dropped.
    assign flush_now = (frame_start && (state == IDLE || state == ADV)) || (state == ADV && pending);
    assign commit    = (state == ADV) && !flush_now;
    assign next_off  = {1'b0, line_off} + (ADDR_W + 1)'(LINE_WORDS);
    assign wrap      = next_off >= (ADDR_W + 1)'(FRAME_WORDS);
    assign addr      = req_access ? (frame_base + line_off + ADDR_W'(word_cnt)) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            line_off <= '0;
            wr_slot  <= '0;
            pending  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == BURST)
                word_cnt <= word_cnt + 1'b1;
            if (flush_now) begin
                line_off <= '0;
                wr_slot  <= '0;
                pending  <= 1'b0;
            end else begin
                if (commit) begin
                    wr_slot  <= wr_slot + 1'b1;
                    line_off <= wrap ? '0 : next_off[ADDR_W-1:0];
                end
                if (frame_start && req_access)
                    pending <= 1'b1;
            end
        end
    end

    assign pix_valid = (lines_avail != '0);
    assign xfer      = pix_valid && pix_ready;
    assign cur_mode  = (rd_ptr[WW-1:0] == '0 && !byte_sel) ? mode_16bpp : line_mode;
    assign word_done = cur_mode || byte_sel;
    assign adv_word  = xfer && word_done;
    assign last_pix  = adv_word && (rd_ptr[WW-1:0] == WW'(LINE_WORDS - 1));
    // Read address runs one word ahead so q always holds the word at rd_ptr.
    assign raddr     = flush_now ? '0 : (adv_word ? rd_ptr + 1'b1 : rd_ptr);
    assign pix_byte  = byte_sel ? q[7:0] : q[15:8];
    assign pix_data  = !pix_valid ? '0 : (cur_mode ? q : {{(DATA_W - 8){1'b0}}, pix_byte});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            byte_sel    <= 1'b0;
            line_mode   <= 1'b0;
            lines_avail <= '0;
            seen_commit <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            line_mode <= cur_mode;
            if (flush_now) begin
                rd_ptr      <= '0;
                byte_sel    <= 1'b0;
                lines_avail <= '0;
            end else begin
                if (adv_word) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    byte_sel <= 1'b0;
                end else if (xfer) begin
                    byte_sel <= 1'b1;
                end
                if (commit && !last_pix)
                    lines_avail <= lines_avail + 1'b1;
                else if (!commit && last_pix)
                    lines_avail <= lines_avail - 1'b1;
            end
            if (frame_start || flush_now)
                seen_commit <= 1'b0;
            else if (commit)
                seen_commit <= 1'b1;
            if (frame_start)
                underflow <= 1'b0;
            else if (seen_commit && pix_ready && !pix_valid)
                underflow <= 1'b1;
        end
    end

    bram_sdp #(
        .DEPTH (NUM_LINES * LINE_WORDS),
        .WIDTH (DATA_W),
        .AW    (SW + WW)
    ) u_ring (
        .clk   (clk),
        .we    (state == BURST),
        .waddr ({wr_slot, word_cnt}),
        .wdata (data),
        .re    (1'b1),
        .raddr (raddr),
        .rdata (q)
    );

endmodule

// File: tb/tb_line_fetch_engine.sv
// Directed bench for line_fetch_engine with a small PSRAM responder.
module tb_line_fetch_engine;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LW     = 128;
    localparam int unsigned NL     = 4;
    localparam int unsigned FW     = 256;
    localparam logic [ADDR_W-1:0] BASE = 23'h100;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] frame_base;
    logic              frame_start, mode_16bpp, ctrlr_good;
    logic              op_begun, data_ok;
    logic [DATA_W-1:0] data;
    logic              req_access, rd, burst;
    logic [ADDR_W-1:0] addr;
    logic              pix_ready, pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic [2:0]        lines_avail;
    logic              underflow;

    logic              dok_en, data_sel;
    int                errors = 0;
    int                checks = 0;
    int                burst_words = 0;
    int                bad, w0, w1;
    logic [ADDR_W-1:0] addr_log [0:4095];

    line_fetch_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LINE_WORDS  (LW),
        .NUM_LINES   (NL),
        .FRAME_WORDS (FW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_base  (frame_base),
        .frame_start (frame_start),
        .mode_16bpp  (mode_16bpp),
        .ctrlr_good  (ctrlr_good),
        .op_begun    (op_begun),
        .data_ok     (data_ok),
        .data        (data),
        .req_access  (req_access),
        .rd          (rd),
        .burst       (burst),
        .addr        (addr),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .lines_avail (lines_avail),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // PSRAM responder: op_begun one cycle after rd, data_ok one cycle into WAIT.
    assign data = data_sel ? 16'hA55A : 16'(addr - BASE);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_begun <= 1'b0;
            data_ok  <= 1'b0;
        end else begin
            op_begun <= rd;
            data_ok  <= dok_en && req_access && !rd && !burst;
        end
    end

    always @(posedge clk) begin
        if (burst) begin
            if (burst_words < 4096) addr_log[burst_words] = addr;
            burst_words++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0; frame_base = BASE; frame_start = 1'b0; mode_16bpp = 1'b1;
        ctrlr_good = 1'b1; pix_ready = 1'b0; dok_en = 1'b1; data_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_access", 32'(req_access), 0);
        check("rst_rd", 32'(rd), 0);
        check("rst_burst", 32'(burst), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_lines_avail", 32'(lines_avail), 0);
        check("rst_underflow", 32'(underflow), 0);
        reset = 1'b1;

        // fill all four slots, FSM must park in IDLE
        for (int i = 0; i < 2000 && !(lines_avail == 3'd4 && !req_access); i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("fill_lines_avail", 32'(lines_avail), 4);
        check("fill_idle", 32'(req_access), 0);
        check("fill_words", 32'(burst_words), 512);
        bad = 0;
        for (int k = 0; k < 512; k++)
            if (addr_log[k] !== BASE + 23'(k % 256)) bad++;
        check("fill_addr_wrap_seq", 32'(bad), 0);
        check("fill_pix_valid", 32'(pix_valid), 1);
        check("fill_pix_data", 32'(pix_data), 0);

        // 16bpp continuous drain
        pix_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (!(pix_valid === 1'b1 && pix_data === 16'(k % 256))) bad++;
            @(negedge clk);
        end
        pix_ready = 1'b0;
        check("stream16_gapless", 32'(bad), 0);
        check("stream16_underflow", 32'(underflow), 0);

        // frame_start while idle flushes immediately
        for (int i = 0; i < 2000 && !(lines_avail == 3'd4 && !req_access); i++) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("flush_lines_avail", 32'(lines_avail), 0);
        check("flush_pix_valid", 32'(pix_valid), 0);
        w0 = burst_words;
        for (int i = 0; i < 1000 && lines_avail != 3'd1; i++) @(negedge clk);
        check("refetch_first_addr", 32'(addr_log[w0]), 32'(BASE));

        // frame_start during second line's burst
        for (int i = 0; i < 200 && !burst; i++) @(negedge clk);
        check("second_line_addr", 32'(addr), 32'(BASE + 23'd128));
        w1 = burst_words;
        repeat (10) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 300 && burst; i++) @(negedge clk);
        check("pending_burst_len", 32'(burst_words - w1), 128);
        @(negedge clk);
        check("pending_discard", 32'(lines_avail), 0);
        for (int i = 0; i < 50 && !burst; i++) @(negedge clk);
        check("pending_restart_addr", 32'(addr), 32'(BASE));

        // reset in the middle of a burst
        for (int i = 0; i < 400 && !(lines_avail == 3'd1 && burst); i++) @(negedge clk);
        data_sel = 1'b1;
        mode_16bpp = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_burst", 32'(burst), 0);
        check("abort_req_access", 32'(req_access), 0);
        check("abort_lines_avail", 32'(lines_avail), 0);
        check("abort_pix_valid", 32'(pix_valid), 0);
        @(negedge clk);
        reset = 1'b1;

        // 8bpp byte order
        for (int i = 0; i < 400 && !pix_valid; i++) @(negedge clk);
        check("pix8_valid", 32'(pix_valid), 1);
        pix_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pix8_byte%0d", k), 32'(pix_data), (k % 2 == 0) ? 32'h00A5 : 32'h005A);
            @(negedge clk);
        end

        // starve the buffer: data_ok held low
        dok_en = 1'b0;
        for (int i = 0; i < 4000 && pix_valid; i++) @(negedge clk);
        check("starve_empty", 32'(pix_valid), 0);
        repeat (2) @(negedge clk);
        check("underflow_set", 32'(underflow), 1);
        repeat (50) @(negedge clk);
        check("underflow_sticky", 32'(underflow), 1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("underflow_clear", 32'(underflow), 0);
        dok_en = 1'b1;
        for (int i = 0; i < 50 && !burst; i++) @(negedge clk);
        for (int i = 0; i < 300 && burst; i++) @(negedge clk);
        for (int i = 0; i < 50 && !burst; i++) @(negedge clk);
        check("restart_after_wait_addr", 32'(addr), 32'(BASE));
        check("restart_lines_avail", 32'(lines_avail), 0);
        repeat (300) @(negedge clk);
        check("refill_underflow", 32'(underflow), 0);
        check("refill_pix_valid", 32'(pix_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_fetch_engine.md
LINE_FETCH_ENGINE -- requirements
Module: line_fetch_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, PSRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, PSRAM/buffer word width.
REQ-003 SHALL have parameter LINE_WORDS, default 128, words per burst line (power of 2).
REQ-004 SHALL have parameter NUM_LINES, default 4, line slots in ring buffer (power of 2, >=2).
REQ-005 SHALL have parameter FRAME_WORDS, default 153600, words per frame before address wrap.
REQ-006 SHALL have port clk  in  1  sole clock; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have ports frame_base  in  ADDR_W  frame start address; frame_start  in  1  one-cycle restart pulse; mode_16bpp  in  1  1=one pixel/word, 0=two 8-bit pixels/word.
REQ-008 SHALL have PSRAM ports ctrlr_good  in  1; op_begun  in  1; data_ok  in  1; data  in  DATA_W; req_access  out  1; rd  out  1; burst  out  1; addr  out  ADDR_W.
REQ-009 SHALL have pixel ports pix_ready  in  1; pix_valid  out  1; pix_data  out  DATA_W (8bpp: byte in [7:0], upper bits zero).
REQ-010 SHALL have status ports lines_avail  out  clog2(NUM_LINES+1)  committed unread lines; underflow  out  1  sticky.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, BURST, ADV.
REQ-012 IDLE->REQ when ctrlr_good=1 and a free slot exists (lines_avail+filling < NUM_LINES); else hold.
REQ-013 REQ: rd=1; ->WAIT on op_begun. WAIT: ->BURST on data_ok.
REQ-014 BURST: burst=1, write data to slot each cycle, word counter +1; after LINE_WORDS writes ->ADV.
REQ-015 ADV: commit slot (lines_avail +1 next cycle), line address +LINE_WORDS; if next offset >= FRAME_WORDS, line address = frame_base; ->IDLE.
REQ-016 req_access SHALL be 1 in REQ, WAIT, BURST only; addr = frame_base + line offset + word counter.
REQ-017 pix_valid=1 iff lines_avail>0 and output register loaded; transfer on pix_valid&pix_ready.
REQ-018 8bpp order: high byte first, then low byte; 16bpp: full word; mode_16bpp sampled only at line boundaries.
REQ-019 Slot freed (lines_avail -1) on transfer of last pixel of a line; simultaneous commit and free SHALL leave lines_avail unchanged.
REQ-020 Buffer read SHALL use prefetched output register so back-to-back transfers sustain one pixel per cycle; first pix_valid within 2 cycles of first commit.
REQ-021 frame_start in IDLE/ADV: flush buffer (lines_avail=0, pointers 0), offset=0. In REQ/WAIT/BURST: latch pending, finish burst, discard that line, then flush.
REQ-022 underflow SHALL set when pix_ready=1, pix_valid=0 after first commit of frame; cleared only by frame_start or reset.
REQ-023 Write and read slot pointers SHALL wrap modulo NUM_LINES.

Reset
REQ-024 On reset=0: state IDLE, rd=0, burst=0, req_access=0, addr=0, pix_valid=0, pix_data=0, lines_avail=0, underflow=0, all pointers/counters 0, pending flag 0.
REQ-025 Reset mid-burst SHALL abort immediately; no buffered data reused after release.

Structure
REQ-026 Shared package SHALL hold FSM state encoding and default parameter constants.
REQ-027 Ring storage SHALL be one sub-module bram_sdp (NUM_LINES*LINE_WORDS x DATA_W, one write, one registered read port).

Verification
REQ-028 ctrlr_good=1, op_begun/data_ok one cycle after request, NUM_LINES=4: 4 bursts of 128 words, lines_avail=4, FSM halts in IDLE.
REQ-029 16bpp, pix_ready=1 continuously, data=incrementing: pix_data 0,1,2,... no gaps, underflow=0.
REQ-030 8bpp, word 16'hA55A: pix_data 8'hA5 then 8'h5A.
REQ-031 FRAME_WORDS=256, LINE_WORDS=128, frame_base=0x100: addr sequence 0x100..0x1FF then 0x100 again.
REQ-032 frame_start during BURST: burst completes 128 words, lines_avail returns 0, next fetch at frame_base.
REQ-033 pix_ready=1 with data_ok held 0 after first line drained: underflow=1 and stays until frame_start.
